count_monitor: RTL and testbench
================================

# count_monitor

Synchronous checker for the free-running 4-bit counter. It samples the counter output `q` and confirms that successive samples advance by exactly one modulo 2^WIDTH. It counts sequence errors and wrap-arounds, and reports lock status. It sits beside the counter in benches and in self-test builds, on the same clock domain as the counter's sampling clock.

## Interface
Parameters:
- `WIDTH`, 4: width of the observed count.
- `SYNC_LEN`, 2: number of consecutive correct increments needed to declare lock (1..15).
- `CNT_W`, 8: width of the error and wrap counters.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high; clears all state.
- `q_in`, input, WIDTH: observed counter value.
- `q_valid`, input, 1: `q_in` is a valid sample this cycle.
- `dut_reset`, input, 1: the counter's own reset, observed; arms the zero check.
- `locked`, output, 1: the monitor is in LOCK.
- `err_pulse`, output, 1: one-cycle flag for a sequence error.
- `err_count`, output, CNT_W: saturating count of sequence errors.
- `wrap_count`, output, CNT_W: saturating count of wrap events (all-ones to 0).
- `expected`, output, WIDTH: value predicted for the next valid sample.

## Operation
- States: IDLE, ARMED, SYNC, LOCK.
- Reset: state is IDLE and every output is 0.
- `dut_reset`=1 in any state:
  - Next state is ARMED, `expected` becomes 0, and the run counter clears.
  - `q_valid` is ignored in that cycle and no comparison is made.
  - `dut_reset` has priority over every other event.
- IDLE: on the first valid sample, `expected` becomes `q_in`+1 and the state moves to SYNC with run=0. No error is possible in IDLE.
- ARMED: on a valid sample:
  - If `q_in`==0, the state moves to LOCK.
  - Otherwise `err_pulse` fires and the state moves to SYNC with run=0.
  - In both cases `expected` becomes `q_in`+1.
- SYNC: on a valid sample:
  - On a match, run increments. When run reaches SYNC_LEN the state moves to LOCK.
  - On a mismatch, run clears and the monitor stays in SYNC. No error is flagged.
  - `expected` always becomes `q_in`+1.
- LOCK: on a valid sample:
  - On a mismatch, `err_pulse` fires, `err_count` increments, and the state moves to SYNC with run=0.
  - `expected` always becomes `q_in`+1. The monitor resynchronises to the observed value.
- Arithmetic:
  - `expected` is computed modulo 2^WIDTH, so all-ones+1 gives 0.
  - `err_count` and `wrap_count` saturate at 2^CNT_W-1 and never roll over.
- Wrap event: in LOCK, a matching sample with `q_in`==0 whose previous sample was all-ones increments `wrap_count`.
- An ARMED error also increments `err_count`.
- With `q_valid`=0 the state and counters hold.

## Timing
- All outputs are registered.
- `err_pulse`, `locked`, the counters, and `expected` update on the edge that samples `q_in`, and are visible the cycle after the sample is presented.
- `err_pulse` is exactly one cycle wide per error. Back-to-back errors are impossible in LOCK because the first error exits to SYNC.
- Lock latency from IDLE: 1 + SYNC_LEN valid samples. From ARMED: 1 valid sample.
- A `reset` asserted mid-run clears everything on the next edge, including the saturated counters.

## Configuration
- `COUNT_MONITOR_WRAP_EN` defined: the wrap detection logic and `wrap_count` register are compiled in as described.
- `COUNT_MONITOR_WRAP_EN` undefined: that logic is removed and `wrap_count` is tied to 0.
- Error checking behaves the same either way.

## Structure
- Shared package `count_monitor_pkg` holds:
  - the state enum `cm_state_t` (IDLE, ARMED, SYNC, LOCK);
  - the default widths.
- Sub-module `sat_counter`: a parameterised saturating incrementer with synchronous clear. It is instantiated twice, for `err_count` and `wrap_count`.

## Test plan
- Reset, then `dut_reset` for 1 cycle, then samples 0,1,2,…,15,0,1 → `locked`=1 after the first sample, `err_count`=0, `wrap_count`=1, `expected`=2.
- LOCK, then the sequence 5,6,8 → `err_pulse` is high for one cycle after sample 8, `err_count`=1, `locked` drops. Then 9,10 → `locked`=1 again (SYNC_LEN=2).
- ARMED, then the first sample is 3 → `err_pulse`=1, `err_count`=1, state SYNC, `expected`=4.
- `dut_reset`=1 and `q_valid`=1 with `q_in`=7 in the same cycle → no error, `expected`=0, state ARMED.
- Force 300 errors with CNT_W=8 → `err_count` holds at 255. Then `reset` → `err_count`=0.
- Build without `COUNT_MONITOR_WRAP_EN` and run the wrap sequence from the first scenario → `wrap_count` stays 0 and all other outputs are identical.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared state type and default widths for the counter monitor.
// The optional wrap detection is controlled by COUNT_MONITOR_WRAP_EN in count_monitor.sv.
package count_monitor_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_SYNC_LEN = 2;
    localparam int DEF_CNT_W    = 8;

    // Run counter only has to reach SYNC_LEN, which is limited to 1..15.
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SYNC  = 2'd2,
        LOCK  = 2'd3
    } cm_state_t;

endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: observed counter signals plus the monitor's status outputs.
// master = the side presenting counter samples, slave = the monitor itself.
interface count_monitor_if
    import count_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [WIDTH-1:0] q_in;
    logic             q_valid;
    logic             dut_reset;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output q_in,
        output q_valid,
        output dut_reset,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  wrap_count,
        input  expected
    );

    modport slave (
        input  q_in,
        input  q_valid,
        input  dut_reset,
        output locked,
        output err_pulse,
        output err_count,
        output wrap_count,
        output expected
    );

endinterface

// File: rtl/count_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Once all-ones is reached further increments are dropped until reset clears it.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear synchronously on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks that a free-running counter advances by one each valid sample.
// Tracks lock, flags and counts sequence errors, and counts wrap-arounds.
// Define COUNT_MONITOR_WRAP_EN to build the wrap detector; otherwise wrap_count is 0.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SYNC_LEN = DEF_SYNC_LEN,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    count_monitor_if.slave  mon
);

    cm_state_t        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             pulse_q, pulse_d;
    logic             err_inc;
    logic             match;
    logic [WIDTH-1:0] q_next;
    logic [RUN_W-1:0] run_inc;

    assign match   = (mon.q_in == exp_q);
    assign q_next  = mon.q_in + WIDTH'(1);
    assign run_inc = run_q + RUN_W'(1);

    // State, run length, prediction and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            exp_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: dut_reset wins, otherwise only valid samples move anything.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        exp_d   = exp_q;
        pulse_d = 1'b0;
        err_inc = 1'b0;

        if (mon.dut_reset) begin
            state_d = ARMED;
            exp_d   = '0;
            run_d   = '0;
        end else if (mon.q_valid) begin
            exp_d = q_next;
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    run_d   = '0;
                end
                ARMED: begin
                    if (mon.q_in == '0) begin
                        state_d = LOCK;
                    end else begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        state_d = SYNC;
                        run_d   = '0;
                    end
                end
                SYNC: begin
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(SYNC_LEN)) begin
                            state_d = LOCK;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCK: begin
                    if (!match) begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        state_d = SYNC;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (mon.err_count)
    );

`ifdef COUNT_MONITOR_WRAP_EN
    // In LOCK a matching 0 means the previous sample was all-ones, i.e. a wrap.
    logic wrap_inc;
    assign wrap_inc = mon.q_valid && !mon.dut_reset && (state_q == LOCK)
                      && match && (mon.q_in == '0);

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .count (mon.wrap_count)
    );
`else
    assign mon.wrap_count = '0;
`endif

    assign mon.locked    = (state_q == LOCK);
    assign mon.err_pulse = pulse_q;
    assign mon.expected  = exp_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed scenarios plus randomized traffic against a behavioural model.
// Honours COUNT_MONITOR_WRAP_EN the same way the design does.
module tb_count_monitor;

    localparam int WIDTH    = 4;
    localparam int SYNC_LEN = 2;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int MODV     = 1 << WIDTH;
`ifdef COUNT_MONITOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    int checks;
    int failures;

    // Behavioural reference: booleans for where the monitor is, plain ints for values.
    bit m_armed, m_hunting, m_locked, m_pulse;
    int m_streak, m_pred, m_errs, m_wraps, m_prev;

    count_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) mon_bus ();

    count_monitor #(
        .WIDTH    (WIDTH),
        .SYNC_LEN (SYNC_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon_bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int wanted);
        checks++;
        if (observed != wanted) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, wanted);
        end
    endtask

    task automatic modelStep(input bit rst, input bit dr, input bit v, input int q);
        bit hit;
        if (rst) begin
            m_armed = 0; m_hunting = 0; m_locked = 0; m_pulse = 0;
            m_streak = 0; m_pred = 0; m_errs = 0; m_wraps = 0; m_prev = -1;
            return;
        end
        m_pulse = 0;
        if (dr) begin
            m_armed = 1; m_hunting = 0; m_locked = 0;
            m_pred = 0; m_streak = 0;
        end else if (v) begin
            hit = (q == m_pred);
            if (m_armed) begin
                m_armed = 0;
                if (q == 0) m_locked = 1;
                else begin
                    m_pulse = 1; m_errs = (m_errs < CNT_MAX) ? m_errs + 1 : CNT_MAX;
                    m_hunting = 1; m_streak = 0;
                end
            end else if (m_locked) begin
                if (!hit) begin
                    m_pulse = 1; m_errs = (m_errs < CNT_MAX) ? m_errs + 1 : CNT_MAX;
                    m_locked = 0; m_hunting = 1; m_streak = 0;
                end else if (q == 0 && m_prev == MODV - 1) begin
                    m_wraps = (m_wraps < CNT_MAX) ? m_wraps + 1 : CNT_MAX;
                end
            end else if (m_hunting) begin
                if (hit) begin
                    m_streak++;
                    if (m_streak == SYNC_LEN) begin
                        m_hunting = 0; m_locked = 1;
                    end
                end else begin
                    m_streak = 0;
                end
            end else begin
                m_hunting = 1; m_streak = 0;
            end
            m_pred = (q + 1) % MODV;
            m_prev = q;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".locked"},     int'(mon_bus.locked),     int'(m_locked));
        checkOutput({tag, ".err_pulse"},  int'(mon_bus.err_pulse),  int'(m_pulse));
        checkOutput({tag, ".err_count"},  int'(mon_bus.err_count),  m_errs);
        checkOutput({tag, ".wrap_count"}, int'(mon_bus.wrap_count), WRAP_EN ? m_wraps : 0);
        checkOutput({tag, ".expected"},   int'(mon_bus.expected),   m_pred);
    endtask

    // Drive one cycle of inputs, step the model on the edge, compare just after it.
    task automatic applyStimulus(input string tag, input bit rst, input bit dr,
                                 input bit v, input int q);
        @(negedge clk);
        reset             = rst;
        mon_bus.dut_reset = dr;
        mon_bus.q_valid   = v;
        mon_bus.q_in      = WIDTH'(q);
        @(posedge clk);
        modelStep(rst, dr, v, q);
        #1;
        checkAll(tag);
    endtask

    initial begin
        int q;
        checks   = 0;
        failures = 0;
        reset             = 1'b1;
        mon_bus.dut_reset = 1'b0;
        mon_bus.q_valid   = 1'b0;
        mon_bus.q_in      = '0;

        // Reset state.
        applyStimulus("reset", 1, 0, 0, 0);
        applyStimulus("reset", 1, 0, 1, 9);
        checkOutput("reset_locked", int'(mon_bus.locked), 0);
        checkOutput("reset_expected", int'(mon_bus.expected), 0);

        // Armed start, full count with wrap.
        applyStimulus("arm", 0, 1, 0, 0);
        for (int i = 0; i < 18; i++) begin
            applyStimulus("count", 0, 0, 1, i % MODV);
            if (i == 0) checkOutput("lock_after_first", int'(mon_bus.locked), 1);
        end
        checkOutput("wrap_locked", int'(mon_bus.locked), 1);
        checkOutput("wrap_errs", int'(mon_bus.err_count), 0);
        checkOutput("wrap_count", int'(mon_bus.wrap_count), WRAP_EN ? 1 : 0);
        checkOutput("wrap_expected", int'(mon_bus.expected), 2);

        // Error in LOCK, then relock after SYNC_LEN matches.
        for (int i = 2; i <= 6; i++) applyStimulus("run", 0, 0, 1, i);
        applyStimulus("skip", 0, 0, 1, 8);
        checkOutput("skip_pulse", int'(mon_bus.err_pulse), 1);
        checkOutput("skip_errs", int'(mon_bus.err_count), 1);
        checkOutput("skip_locked", int'(mon_bus.locked), 0);
        applyStimulus("resync", 0, 0, 1, 9);
        checkOutput("pulse_one_cycle", int'(mon_bus.err_pulse), 0);
        applyStimulus("resync", 0, 0, 1, 10);
        checkOutput("relock", int'(mon_bus.locked), 1);

        // Hold with q_valid low.
        for (int i = 0; i < 3; i++) applyStimulus("hold", 0, 0, 0, 3);
        checkOutput("hold_expected", int'(mon_bus.expected), 11);

        // Armed error on a non-zero first sample.
        applyStimulus("rst2", 1, 0, 0, 0);
        applyStimulus("arm2", 0, 1, 0, 0);
        applyStimulus("armerr", 0, 0, 1, 3);
        checkOutput("armerr_pulse", int'(mon_bus.err_pulse), 1);
        checkOutput("armerr_errs", int'(mon_bus.err_count), 1);
        checkOutput("armerr_expected", int'(mon_bus.expected), 4);
        checkOutput("armerr_locked", int'(mon_bus.locked), 0);

        // dut_reset beats a simultaneous valid sample.
        applyStimulus("drprio", 0, 1, 1, 7);
        checkOutput("drprio_pulse", int'(mon_bus.err_pulse), 0);
        checkOutput("drprio_expected", int'(mon_bus.expected), 0);
        applyStimulus("drprio_zero", 0, 0, 1, 0);
        checkOutput("drprio_armed", int'(mon_bus.locked), 1);

        // Randomized traffic, mostly well-behaved samples.
        for (int i = 0; i < 600; i++) begin
            q = ($urandom_range(0, 9) < 8) ? m_pred : int'($urandom_range(0, MODV - 1));
            applyStimulus("rand", $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7, q);
        end

        // Saturate the error counter, then clear it with reset.
        for (int i = 0; i < 300; i++) begin
            applyStimulus("sat_arm", 0, 1, 0, 0);
            applyStimulus("sat_err", 0, 0, 1, 5);
        end
        checkOutput("sat_errs", int'(mon_bus.err_count), CNT_MAX);
        applyStimulus("sat_clear", 1, 0, 0, 0);
        checkOutput("sat_cleared", int'(mon_bus.err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
